// File: rtl/fifo_uart_pkg.sv
// Shared types for the FIFO-draining UART transmitter: FSM state encoding and frame constants.
// No logic and no latency; frame geometry is fixed at 8 data bits and 1 stop bit.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  localparam int DATA_W    = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick pulses on the last cycle of every CLKS_PER_BIT-cycle period.
// Latency: tick is decoded from the count; no backpressure, clear restarts the period at count 0.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A clear cycle never ends a period, so the first bit after it is a full period long.
  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain to 8N1 UART (8E1 with FIFO_UART_TX_PARITY_EN): pops one byte, first start bit 3 cycles after the pop decision.
// Backpressure: tx_en is honoured only between frames; a frame in flight always completes.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              tx_busy,
  output logic [7:0]        frame_cnt
);

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [2:0]        bit_idx;
  logic              tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state == LOAD),
    .tick (tick)
  );

  assign fifo_rd_en = (state == FETCH);
  assign tx_busy    = (state != IDLE);

  // tx is updated on the same edge as the state, so the line level always matches the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      frame_cnt <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_en && !fifo_empty) state <= FETCH;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shift_reg <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_bit <= ^fifo_data;
`endif
          tx    <= 1'b0;
          state <= START;
        end
        START: begin
          if (tick) begin
            tx    <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == 3'(DATA_W - 1)) begin
              bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_reg[1];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          // bit_idx is reused to count stop bits.
          if (tick) begin
            if (bit_idx == 3'(STOP_BITS - 1)) begin
              bit_idx   <= '0;
              frame_cnt <= frame_cnt + 8'd1;
              state     <= IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model with registered read, per-cycle line checks against a frame model.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int CPB   = 8;
  localparam int NBITS = 11;
`else
  localparam int CPB   = 4;
  localparam int NBITS = 10;
`endif
  localparam int FLEN     = NBITS * CPB;
  localparam int WAIT_MAX = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       tx_busy;
  logic [7:0] frame_cnt;

  int asserts = 0;
  int fails = 0;
  int pops = 0;
  int bad_pops = 0;
  int exp_frames = 0;

  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;

  logic cap [0:FLEN-1];
  int   cap_gap;
  bit   cap_to;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // FIFO with one-cycle registered read.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      pops <= pops + 1;
      if (fifo_empty) begin
        bad_pops <= bad_pops + 1;
      end else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 8'd1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Expected line level k cycles after the start bit begins.
  function automatic logic model_bit(input logic [7:0] b, input int k);
    int pos;
    pos = k / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called at a negedge: counts idle-high cycles until the start bit, then records one frame.
  task automatic capture(input int drop_at);
    cap_gap = 0;
    cap_to  = 1'b0;
    while (tx !== 1'b0 && cap_gap < WAIT_MAX) begin
      cap_gap++;
      @(negedge clk);
    end
    if (tx !== 1'b0) cap_to = 1'b1;
    for (int k = 0; k < FLEN; k++) begin
      cap[k] = tx;
      if (k == drop_at) tx_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tx_en = 1'b1;
    repeat (3) @(negedge clk);
    asserts++;
    if ({tx, tx_busy, fifo_rd_en} !== 3'b100 || frame_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: tx/busy/rd=%b%b%b cnt=%0d, expected 100 cnt=0", tx, tx_busy, fifo_rd_en, frame_cnt);
    end
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      asserts++;
      if ({tx, tx_busy, fifo_rd_en} !== 3'b100) begin
        fails++;
        $display("FAIL idle_empty cycle %0d: tx/busy/rd=%b%b%b expected 100", i, tx, tx_busy, fifo_rd_en);
      end
    end
    asserts++;
    if (frame_cnt !== 8'd0) begin
      fails++;
      $display("FAIL idle_frame_cnt: got %0d expected 0", frame_cnt);
    end
  endtask

  task automatic test_single();
    int p0;
    p0 = pops;
    push(8'hA5);
    capture(-1);
    asserts++;
    if (cap_to) begin fails++; $display("FAIL single_start: no start bit within %0d cycles", WAIT_MAX); end
    for (int k = 0; k < FLEN; k++) begin
      asserts++;
      if (cap[k] !== model_bit(8'hA5, k)) begin
        fails++;
        $display("FAIL single_tx cycle %0d: tx=%b expected %b", k, cap[k], model_bit(8'hA5, k));
      end
    end
    exp_frames++;
    asserts++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL single_end: busy=%b tx=%b after %0d cycles, expected busy=0 tx=1", tx_busy, tx, FLEN);
    end
    asserts++;
    if (pops - p0 !== 1) begin fails++; $display("FAIL single_pops: got %0d expected 1", pops - p0); end
    asserts++;
    if (frame_cnt !== 8'(exp_frames)) begin fails++; $display("FAIL single_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [0:4];
    int p0;
    p0 = pops;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    for (int i = 2; i < 5; i++) bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) push(bytes[i]);
    for (int i = 0; i < 5; i++) begin
      capture(-1);
      asserts++;
      if (cap_to || cap_gap !== 3) begin
        fails++;
        $display("FAIL b2b_gap frame %0d: %0d idle cycles (timeout=%0d) expected 3", i, cap_gap, cap_to);
      end
      for (int k = 0; k < FLEN; k++) begin
        asserts++;
        if (cap[k] !== model_bit(bytes[i], k)) begin
          fails++;
          $display("FAIL b2b_tx frame %0d byte %h cycle %0d: tx=%b expected %b", i, bytes[i], k, cap[k], model_bit(bytes[i], k));
        end
      end
      exp_frames++;
    end
    asserts++;
    if (pops - p0 !== 5) begin fails++; $display("FAIL b2b_pops: got %0d expected 5", pops - p0); end
    asserts++;
    if (frame_cnt !== 8'(exp_frames)) begin fails++; $display("FAIL b2b_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_tx_en_gating();
    logic [7:0] nxt;
    int p0;
    p0 = pops;
    nxt = 8'($urandom_range(0, 255));
    push(8'h3C);
    push(nxt);
    capture(4 * CPB + 1);
    asserts++;
    if (cap_to) begin fails++; $display("FAIL gate_start: no start bit within %0d cycles", WAIT_MAX); end
    for (int k = 0; k < FLEN; k++) begin
      asserts++;
      if (cap[k] !== model_bit(8'h3C, k)) begin
        fails++;
        $display("FAIL gate_tx cycle %0d: tx=%b expected %b", k, cap[k], model_bit(8'h3C, k));
      end
    end
    exp_frames++;
    for (int i = 0; i < 20; i++) begin
      asserts++;
      if ({tx, tx_busy, fifo_rd_en} !== 3'b100) begin
        fails++;
        $display("FAIL gate_hold cycle %0d: tx/busy/rd=%b%b%b expected 100", i, tx, tx_busy, fifo_rd_en);
      end
      @(negedge clk);
    end
    asserts++;
    if (pops - p0 !== 1) begin fails++; $display("FAIL gate_pops_held: got %0d expected 1", pops - p0); end
    tx_en = 1'b1;
    capture(-1);
    asserts++;
    if (cap_to || cap_gap !== 3) begin
      fails++;
      $display("FAIL gate_resume_gap: %0d cycles (timeout=%0d) expected 3", cap_gap, cap_to);
    end
    for (int k = 0; k < FLEN; k++) begin
      asserts++;
      if (cap[k] !== model_bit(nxt, k)) begin
        fails++;
        $display("FAIL gate_resume_tx byte %h cycle %0d: tx=%b expected %b", nxt, k, cap[k], model_bit(nxt, k));
      end
    end
    exp_frames++;
    asserts++;
    if (frame_cnt !== 8'(exp_frames)) begin fails++; $display("FAIL gate_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_async_reset();
    logic [7:0] b;
    int n;
    b = 8'($urandom_range(0, 255));
    push(b);
    n = 0;
    while (tx !== 1'b0 && n < WAIT_MAX) begin n++; @(negedge clk); end
    asserts++;
    if (tx !== 1'b0) begin fails++; $display("FAIL arst_start: no start bit within %0d cycles", WAIT_MAX); end
    repeat (2 * CPB + 1) @(negedge clk);
    asserts++;
    if (tx_busy !== 1'b1) begin fails++; $display("FAIL arst_busy_before: busy=%b expected 1", tx_busy); end
    #2 rst = 1'b0;
    #1;
    asserts++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || frame_cnt !== 8'd0) begin
      fails++;
      $display("FAIL arst_immediate: tx=%b busy=%b cnt=%0d expected tx=1 busy=0 cnt=0", tx, tx_busy, frame_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    exp_frames = 0;
    b = 8'($urandom_range(0, 255));
    push(b);
    capture(-1);
    asserts++;
    if (cap_to || cap_gap !== 3) begin
      fails++;
      $display("FAIL arst_restart_gap: %0d cycles (timeout=%0d) expected 3", cap_gap, cap_to);
    end
    for (int k = 0; k < FLEN; k++) begin
      asserts++;
      if (cap[k] !== model_bit(b, k)) begin
        fails++;
        $display("FAIL arst_tx byte %h cycle %0d: tx=%b expected %b", b, k, cap[k], model_bit(b, k));
      end
    end
    exp_frames++;
    asserts++;
    if (frame_cnt !== 8'(exp_frames)) begin fails++; $display("FAIL arst_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
    asserts++;
    if (bad_pops !== 0) begin fails++; $display("FAIL pop_while_empty: got %0d expected 0", bad_pops); end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes [0:1];
    logic       par [0:1];
    bytes[0] = 8'h07; par[0] = 1'b1;
    bytes[1] = 8'hA5; par[1] = 1'b0;
    push(bytes[0]);
    push(bytes[1]);
    for (int i = 0; i < 2; i++) begin
      capture(-1);
      asserts++;
      if (cap_to) begin fails++; $display("FAIL parity_start frame %0d: no start bit", i); end
      asserts++;
      if (cap[9 * CPB] !== par[i] || cap[10 * CPB - 1] !== par[i]) begin
        fails++;
        $display("FAIL parity_bit byte %h: tx=%b/%b expected %b", bytes[i], cap[9 * CPB], cap[10 * CPB - 1], par[i]);
      end
      for (int k = 0; k < FLEN; k++) begin
        asserts++;
        if (cap[k] !== model_bit(bytes[i], k)) begin
          fails++;
          $display("FAIL parity_tx byte %h cycle %0d: tx=%b expected %b", bytes[i], k, cap[k], model_bit(bytes[i], k));
        end
      end
      exp_frames++;
    end
    asserts++;
    if (tx_busy !== 1'b0 || frame_cnt !== 8'(exp_frames)) begin
      fails++;
      $display("FAIL parity_end: busy=%b cnt=%0d expected busy=0 cnt=%0d", tx_busy, frame_cnt, exp_frames);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_tx_en_gating();
    test_async_reset();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 8-bit FIFO. It pops one byte at a time through the FIFO's read port and serialises each byte as an 8N1 UART frame on a single line: start bit, 8 data bits LSB first, stop bit. It matches the FIFO's one-cycle registered read latency, so the data byte is valid one cycle after the read strobe.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit period; must be >= 2.
- CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter; derived, never overridden.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- tx_en  input  1  1 = permit new frames; 0 = finish the current frame, then stay idle.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_en  output  1  single-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high in every state except IDLE.
- frame_cnt  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (rst=0, asynchronous), effective immediately, even mid-frame:
  - tx=1, fifo_rd_en=0, tx_busy=0, frame_cnt=0.
  - state=IDLE, baud counter=0, bit index=0, shift register=0.
- Registered outputs: tx, frame_cnt. fifo_rd_en is decoded combinationally as (state==FETCH). tx_busy is decoded as (state!=IDLE).
- IDLE: tx=1. If tx_en && !fifo_empty, go to FETCH. Otherwise stay in IDLE.
- FETCH (1 cycle): fifo_rd_en=1. Always go to LOAD. fifo_empty is not re-sampled here.
- LOAD (1 cycle): capture shift_reg <= fifo_data. Go to START with baud counter=0.
- START: tx=0 for exactly CLKS_PER_BIT cycles.
- DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles per bit.
  - At the end of each bit period, shift right and increment the bit index.
  - After bit index 7, go to PARITY if compiled in, else STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end, frame_cnt += 1 and go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. The bit period ends on the cycle where counter==CLKS_PER_BIT-1; the counter then returns to 0.
- Frame length: 10*CLKS_PER_BIT cycles (11* with parity). A frame starts on the first tx=0 cycle.
- Back-to-back bytes: IDLE->FETCH->LOAD adds 3 idle-high cycles after the stop bit. The next start bit begins 3 cycles after the previous STOP ends.
- tx_en deassertion:
  - Mid-frame: no effect; the frame completes normally.
  - In IDLE: blocks the transition to FETCH.
  - Sampled only in IDLE.
- fifo_empty rising while in FETCH or LOAD: cannot occur (the FIFO was non-empty when sampled). No special handling required.
- One pop per frame: fifo_rd_en is never asserted while fifo_empty=1 was sampled in IDLE.
- Reset during FETCH: the FIFO pop may still occur in the FIFO's clock domain. Losing that byte is acceptable and documented.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
  - The parity bit is computed at LOAD from fifo_data and held in a register.
- Undefined: no PARITY state, no parity register; 8N1 framing only.

Decomposition:
- Shared package fifo_uart_pkg holds:
  - State enum: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP (3-bit encoding).
  - Constants DATA_W=8 and STOP_BITS=1.
- Natural sub-module: uart_baud_tick.
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clk, rst, clear. Output: a tick pulse at the end of each bit period.
  - Instantiated once; the FSM clears it on LOAD.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset then idle: rst=0 for 3 cycles, then rst=1 with fifo_empty=1 for 50 cycles -> tx=1, fifo_rd_en never asserted, tx_busy=0, frame_cnt=0.
- Single byte 0xA5:
  - Stimulus: fifo_empty=0 for one pop; FIFO model returns 0xA5 one cycle after the strobe.
  - Required: exactly one fifo_rd_en pulse.
  - Required: tx sequence in 4-cycle periods is 0,1,0,1,0,0,1,0,1,1; 40 cycles from start bit to end of stop bit.
  - Required: frame_cnt=1.
- Back-to-back: FIFO holds 0x00, 0xFF -> two frames; exactly 3 tx=1 cycles between the first stop-bit end and the second start bit; frame_cnt=2.
- tx_en gating:
  - Stimulus: deassert tx_en during the DATA bit 3 of 0x3C, with the FIFO non-empty.
  - Required: the frame completes; no further fifo_rd_en until tx_en=1; then the next frame starts after 3 cycles.
- Async reset mid-frame: rst=0 asynchronously during DATA -> tx=1 and tx_busy=0 before the next clk edge; frame_cnt=0; next frame starts cleanly after release.
- FIFO_UART_TX_PARITY_EN defined, CLKS_PER_BIT=8: byte 0x07 -> parity bit 1; frame length 88 cycles. Byte 0xA5 -> parity bit 0.
